xram_accel_router: RTL and testbench
====================================

Name: xram_accel_router

Overview:
Parameterised XRAM-side router between the 8051 core's XRAM port and N memory-mapped accelerators (AES, SHA, future engines). It replaces fixed fan-out wiring, where every accelerator snoops one shared cmd/addr/data bus. Instead it decodes each CPU access into a per-accelerator address window, drives a held command handshake to exactly one accelerator, and returns read data to the CPU through an ack handshake. Unmapped accesses, and (optionally) hung accelerators, are absorbed without stalling the CPU forever.

Parameters:
N_ACC, 2, number of accelerator channels (1..8)
ADDR_W, 16, XRAM address width
DATA_W, 8, XRAM data width
BASE_ADDR, 16'hFE00, start of channel 0 window
WIN_BITS, 8, log2 window size; channel i window = BASE_ADDR + i*2^WIN_BITS .. +2^WIN_BITS-1
TIMEOUT, 15, max BUSY cycles before abort (used only with the optional feature)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
xram_addr  in  ADDR_W  CPU access address, stable until xram_ack
xram_data_out  in  DATA_W  CPU write data
xram_write  in  1  CPU write request (level)
xram_read  in  1  CPU read request (level)
xram_data_in  out  DATA_W  read data to CPU, valid when xram_ack=1
xram_ack  out  1  one-cycle completion pulse
acc_cmd  out  2*N_ACC  per-channel command: 0 NOP, 1 READ, 2 WRITE
acc_addr  out  ADDR_W  registered address, shared by all channels
acc_data  out  DATA_W  registered write data, shared
acc_rdata  in  N_ACC*DATA_W  per-channel read data
acc_ack  in  N_ACC  per-channel completion, sampled while its cmd is non-NOP
acc_grant  out  N_ACC  per-channel step enable
err_timeout  out  1  sticky abort flag

Behaviour:
- Reset (rst=0, async): state IDLE. acc_cmd=0, acc_addr=0, acc_data=0, xram_data_in=0, xram_ack=0, err_timeout=0, acc_grant=all ones, BUSY counter=0.
- FSM states IDLE, BUSY, RESP.
- IDLE:
  - If xram_write|xram_read: latch addr, data, op (write wins if both asserted) and decoded channel sel.
  - Hit: go to BUSY; acc_cmd[sel] = op from the next cycle.
  - Miss (outside all windows, or channel disabled): go to RESP directly; read data = all ones; write dropped.
- BUSY:
  - acc_cmd[sel] held; all other channels NOP.
  - On acc_ack[sel]=1: capture acc_rdata[sel] (reads only), drop cmd to NOP in the next cycle, go to RESP.
  - acc_ack of unselected channels is ignored.
- RESP:
  - xram_ack=1 for exactly one cycle; xram_data_in holds its value until the next RESP.
  - Return to IDLE. Requests are not sampled in RESP, so the CPU must drop its request on ack.
- Latency (request first seen in IDLE at cycle T):
  - Hit with same-cycle accelerator ack: xram_ack at T+2.
  - Each extra wait cycle adds 1.
  - Miss: xram_ack at T+1.
- Decode: channel = (addr - BASE_ADDR) >> WIN_BITS.
  - Hit iff addr >= BASE_ADDR and channel < N_ACC.
  - Width-safe: the subtraction must not wrap into a false hit.
- acc_addr/acc_data stay at their last values when idle; accelerators must qualify them with acc_cmd.
- Reset during BUSY: cmd drops asynchronously and no ack is produced.

Optional Feature:
Macro XRAM_ROUTER_TIMEOUT_EN.
- With it:
  - BUSY counts cycles. After TIMEOUT cycles without acc_ack[sel], cmd is forced to NOP and the FSM goes to RESP with read data = all ones.
  - err_timeout is set (sticky until reset) and acc_grant[sel] is cleared.
  - A disabled channel decodes as a miss until reset.
- Without it:
  - BUSY waits indefinitely.
  - err_timeout is tied to 0 and acc_grant is tied to all ones.

Decomposition:
- Package xram_router_pkg holds:
  - cmd encodings CMD_NOP/CMD_RD/CMD_WR
  - FSM state typedef
  - the all-ones miss-data constant function
- Natural sub-module: xram_addr_decode, combinational (addr, enable mask → hit, sel), parameterised by N_ACC, BASE_ADDR, WIN_BITS.

Test Plan:
All tests use N_ACC=2, defaults (ch0 FE00–FEFF, ch1 FF00–FFFF), TIMEOUT=15.
- Reset → all outputs at reset values, acc_grant=2'b11, no ack while both requests are low.
- Write FE10 data 5A, acc_ack[0] held high → acc_cmd=4'b0010 for one cycle, acc_addr=FE10, acc_data=5A, xram_ack at T+2, ch1 stays NOP.
- Read FF05, acc_ack[1] arrives 3 cycles after cmd with rdata 3C → acc_cmd[3:2]=1 for 4 cycles, xram_data_in=3C with xram_ack at T+5.
- Read 1234 (miss) and simultaneous read+write to FDFF → each acks at T+1 with data FF, no acc_cmd activity.
- Timeout enabled, read FE00 with no ack → xram_ack after 15 BUSY cycles, data FF, err_timeout=1, acc_grant=2'b10; a subsequent write to FE00 acks at T+1 with no cmd.
- Reset asserted mid-BUSY on ch1 → acc_cmd=0 immediately, no xram_ack; after release, the next read to FF00 completes normally.

Source files
------------

// File: rtl/xram_accel_router_pkg.sv
// Shared types for the XRAM accelerator router: command encodings, FSM states
// and the all-ones fill value returned for unmapped or aborted reads.
package xram_router_pkg;

  typedef enum logic [1:0] {
    CMD_NOP = 2'd0,
    CMD_RD  = 2'd1,
    CMD_WR  = 2'd2
  } acc_cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } rtr_state_e;

  localparam int MAX_DATA_W = 64;

  function automatic logic [MAX_DATA_W-1:0] miss_data(input int width);
    logic [MAX_DATA_W-1:0] v;
    v = '0;
    for (int i = 0; i < MAX_DATA_W; i++) begin
      if (i < width) v[i] = 1'b1;
    end
    return v;
  endfunction

endpackage

// File: rtl/xram_accel_router_if.sv
// CPU-side XRAM port and accelerator-side command bus used by the router.
// The router is the slave of the CPU interface and the master of the accelerator interface.
interface xram_cpu_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
) ();
  logic [ADDR_W-1:0] xram_addr;
  logic [DATA_W-1:0] xram_data_out;
  logic              xram_write;
  logic              xram_read;
  logic [DATA_W-1:0] xram_data_in;
  logic              xram_ack;

  modport master (
    output xram_addr, xram_data_out, xram_write, xram_read,
    input  xram_data_in, xram_ack
  );

  modport slave (
    input  xram_addr, xram_data_out, xram_write, xram_read,
    output xram_data_in, xram_ack
  );
endinterface

interface xram_acc_if #(
  parameter int N_ACC  = 2,
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
) ();
  logic [2*N_ACC-1:0]      acc_cmd;
  logic [ADDR_W-1:0]       acc_addr;
  logic [DATA_W-1:0]       acc_data;
  logic [N_ACC*DATA_W-1:0] acc_rdata;
  logic [N_ACC-1:0]        acc_ack;
  logic [N_ACC-1:0]        acc_grant;

  modport master (
    output acc_cmd, acc_addr, acc_data, acc_grant,
    input  acc_rdata, acc_ack
  );

  modport slave (
    input  acc_cmd, acc_addr, acc_data, acc_grant,
    output acc_rdata, acc_ack
  );
endinterface

// File: rtl/xram_accel_router_addr_decode.sv
// Maps an XRAM address onto one of N_ACC equal-size accelerator windows.
// A channel whose enable bit is low decodes as a miss.
module xram_addr_decode #(
  parameter int                N_ACC     = 2,
  parameter int                ADDR_W    = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 16'hFE00,
  parameter int                WIN_BITS  = 8,
  localparam int               SEL_W     = (N_ACC > 1) ? $clog2(N_ACC) : 1
) (
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [N_ACC-1:0]  en_i,
  output logic              hit_o,
  output logic [SEL_W-1:0]  sel_o
);

  logic              above;
  logic [ADDR_W-1:0] offset;
  logic [ADDR_W-1:0] chan;

  // The offset is only trusted when addr >= base, so a wrapped subtraction never hits.
  always_comb begin
    above  = (addr_i >= BASE_ADDR);
    offset = addr_i - BASE_ADDR;
    chan   = offset >> WIN_BITS;
    hit_o  = 1'b0;
    sel_o  = '0;
    for (int i = 0; i < N_ACC; i++) begin
      if (above && (chan == ADDR_W'(i)) && en_i[i]) begin
        hit_o = 1'b1;
        sel_o = SEL_W'(i);
      end
    end
  end

endmodule

// File: rtl/xram_accel_router.sv
// Routes 8051 XRAM accesses to one of N_ACC accelerators and returns an ack.
// Optional hung-accelerator abort is enabled with `define XRAM_ROUTER_TIMEOUT_EN.
//
//   state   | meaning
//   IDLE    | waiting for xram_read/xram_write, decode and latch the access
//   BUSY    | command held on the selected channel until its acc_ack
//   RESP    | one-cycle xram_ack to the CPU, then back to IDLE
module xram_accel_router
  import xram_router_pkg::*;
#(
  parameter int                N_ACC     = 2,
  parameter int                ADDR_W    = 16,
  parameter int                DATA_W    = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 16'hFE00,
  parameter int                WIN_BITS  = 8,
  parameter int                TIMEOUT   = 15
) (
  input  logic       clk,
  input  logic       rst,
  xram_cpu_if.slave  cpu,
  xram_acc_if.master acc,
  output logic       err_timeout
);

  localparam int SEL_W = (N_ACC > 1) ? $clog2(N_ACC) : 1;
  localparam logic [MAX_DATA_W-1:0] MISS_FULL = miss_data(DATA_W);
  localparam logic [DATA_W-1:0]     MISS_DATA = MISS_FULL[DATA_W-1:0];

  rtr_state_e         state_q, state_d;
  logic [2*N_ACC-1:0] cmd_q, cmd_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic [DATA_W-1:0]  rdata_q, rdata_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  acc_cmd_e           op_q, op_d;

  logic               req;
  acc_cmd_e           req_op;
  logic [N_ACC-1:0]   dec_en;
  logic               dec_hit;
  logic [SEL_W-1:0]   dec_sel;
  logic               ack_sel;
  logic [DATA_W-1:0]  rdata_sel;

`ifdef XRAM_ROUTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N_ACC-1:0] en_q, en_d;
  logic             err_q, err_d;

  assign dec_en        = en_q;
  assign acc.acc_grant = en_q;
  assign err_timeout   = err_q;
`else
  assign dec_en        = '1;
  assign acc.acc_grant = '1;
  assign err_timeout   = 1'b0;
`endif

  assign req    = cpu.xram_write | cpu.xram_read;
  assign req_op = cpu.xram_write ? CMD_WR : CMD_RD;

  xram_addr_decode #(
    .N_ACC    (N_ACC),
    .ADDR_W   (ADDR_W),
    .BASE_ADDR(BASE_ADDR),
    .WIN_BITS (WIN_BITS)
  ) u_decode (
    .addr_i(cpu.xram_addr),
    .en_i  (dec_en),
    .hit_o (dec_hit),
    .sel_o (dec_sel)
  );

  always_comb begin
    ack_sel   = 1'b0;
    rdata_sel = '0;
    for (int i = 0; i < N_ACC; i++) begin
      if (sel_q == SEL_W'(i)) begin
        ack_sel   = acc.acc_ack[i];
        rdata_sel = acc.acc_rdata[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    addr_d  = addr_q;
    data_d  = data_q;
    rdata_d = rdata_q;
    sel_d   = sel_q;
    op_d    = op_q;
`ifdef XRAM_ROUTER_TIMEOUT_EN
    cnt_d   = cnt_q;
    en_d    = en_q;
    err_d   = err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          addr_d = cpu.xram_addr;
          data_d = cpu.xram_data_out;
          op_d   = req_op;
          sel_d  = dec_sel;
          if (dec_hit) begin
            state_d = ST_BUSY;
            cmd_d   = '0;
            for (int i = 0; i < N_ACC; i++) begin
              if (dec_sel == SEL_W'(i)) cmd_d[2*i +: 2] = req_op;
            end
`ifdef XRAM_ROUTER_TIMEOUT_EN
            cnt_d = CNT_W'(TIMEOUT - 1);
`endif
          end else begin
            state_d = ST_RESP;
            rdata_d = MISS_DATA;
          end
        end
      end
      ST_BUSY: begin
        if (ack_sel) begin
          if (op_q == CMD_RD) rdata_d = rdata_sel;
          cmd_d   = '0;
          state_d = ST_RESP;
        end
`ifdef XRAM_ROUTER_TIMEOUT_EN
        // Abort on the last allowed BUSY cycle; the channel stays fenced off until reset.
        else if (cnt_q == '0) begin
          cmd_d       = '0;
          rdata_d     = MISS_DATA;
          err_d       = 1'b1;
          en_d[sel_q] = 1'b0;
          state_d     = ST_RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
`endif
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cmd_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      rdata_q <= '0;
      sel_q   <= '0;
      op_q    <= CMD_NOP;
`ifdef XRAM_ROUTER_TIMEOUT_EN
      cnt_q   <= '0;
      en_q    <= '1;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      rdata_q <= rdata_d;
      sel_q   <= sel_d;
      op_q    <= op_d;
`ifdef XRAM_ROUTER_TIMEOUT_EN
      cnt_q   <= cnt_d;
      en_q    <= en_d;
      err_q   <= err_d;
`endif
    end
  end

  assign acc.acc_cmd      = cmd_q;
  assign acc.acc_addr     = addr_q;
  assign acc.acc_data     = data_q;
  assign cpu.xram_data_in = rdata_q;
  assign cpu.xram_ack     = (state_q == ST_RESP);

endmodule

// File: tb/tb_xram_accel_router.sv
// Directed bench for xram_accel_router with two channels at FE00/FF00.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_xram_accel_router;
  import xram_router_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic err_timeout;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  xram_cpu_if #(.ADDR_W(16), .DATA_W(8)) cpu_if ();
  xram_acc_if #(.N_ACC(2), .ADDR_W(16), .DATA_W(8)) acc_if ();

  xram_accel_router #(
    .N_ACC    (2),
    .ADDR_W   (16),
    .DATA_W   (8),
    .BASE_ADDR(16'hFE00),
    .WIN_BITS (8),
    .TIMEOUT  (15)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cpu        (cpu_if),
    .acc        (acc_if),
    .err_timeout(err_timeout)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic cpu_req(input logic [15:0] addr, input logic [7:0] wdata,
                         input logic rd, input logic wr);
    cpu_if.xram_addr     = addr;
    cpu_if.xram_data_out = wdata;
    cpu_if.xram_read     = rd;
    cpu_if.xram_write    = wr;
  endtask

  task automatic cpu_drop();
    cpu_if.xram_read  = 1'b0;
    cpu_if.xram_write = 1'b0;
  endtask

  initial begin
    cpu_req(16'h0000, 8'h00, 1'b0, 1'b0);
    acc_if.acc_ack   = 2'b00;
    acc_if.acc_rdata = 16'h0000;

    // reset values
    tick();
    tick();
    chk("rst_cmd", acc_if.acc_cmd, 4'b0000);
    chk("rst_addr", acc_if.acc_addr, 16'h0000);
    chk("rst_data", acc_if.acc_data, 8'h00);
    chk("rst_rdata", cpu_if.xram_data_in, 8'h00);
    chk("rst_ack", cpu_if.xram_ack, 1'b0);
    chk("rst_err", err_timeout, 1'b0);
    chk("rst_grant", acc_if.acc_grant, 2'b11);
    rst = 1'b1;
    tick();
    chk("idle_ack0", cpu_if.xram_ack, 1'b0);
    tick();
    chk("idle_ack1", cpu_if.xram_ack, 1'b0);
    chk("idle_cmd", acc_if.acc_cmd, 4'b0000);

    // write FE10 <- 5A, ch0 acks immediately
    cpu_req(16'hFE10, 8'h5A, 1'b0, 1'b1);
    acc_if.acc_ack = 2'b01;
    tick();
    chk("wr_cmd", acc_if.acc_cmd, 4'b0010);
    chk("wr_addr", acc_if.acc_addr, 16'hFE10);
    chk("wr_data", acc_if.acc_data, 8'h5A);
    chk("wr_ack_t1", cpu_if.xram_ack, 1'b0);
    tick();
    chk("wr_ack_t2", cpu_if.xram_ack, 1'b1);
    chk("wr_cmd_t2", acc_if.acc_cmd, 4'b0000);
    cpu_drop();
    acc_if.acc_ack = 2'b00;
    tick();
    chk("wr_ack_t3", cpu_if.xram_ack, 1'b0);

    // read FF05, ch1 acks 3 cycles after cmd; ch0 ack noise ignored
    cpu_req(16'hFF05, 8'h00, 1'b1, 1'b0);
    acc_if.acc_ack   = 2'b01;
    acc_if.acc_rdata = {8'h00, 8'hAA};
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk("rd1_cmd_wait", acc_if.acc_cmd, 4'b0100);
      chk("rd1_ack_wait", cpu_if.xram_ack, 1'b0);
    end
    tick();
    chk("rd1_cmd_t4", acc_if.acc_cmd, 4'b0100);
    chk("rd1_ack_t4", cpu_if.xram_ack, 1'b0);
    acc_if.acc_ack   = 2'b10;
    acc_if.acc_rdata = {8'h3C, 8'hAA};
    tick();
    chk("rd1_ack_t5", cpu_if.xram_ack, 1'b1);
    chk("rd1_data", cpu_if.xram_data_in, 8'h3C);
    chk("rd1_cmd_t5", acc_if.acc_cmd, 4'b0000);
    cpu_drop();
    acc_if.acc_ack = 2'b00;
    tick();
    chk("rd1_ack_off", cpu_if.xram_ack, 1'b0);
    chk("rd1_data_hold", cpu_if.xram_data_in, 8'h3C);

    // read+write to FDFF: just below the windows, miss
    cpu_req(16'hFDFF, 8'h44, 1'b1, 1'b1);
    tick();
    chk("rw_miss_ack", cpu_if.xram_ack, 1'b1);
    chk("rw_miss_data", cpu_if.xram_data_in, 8'hFF);
    chk("rw_miss_cmd", acc_if.acc_cmd, 4'b0000);
    cpu_drop();
    tick();
    chk("rw_miss_ack_off", cpu_if.xram_ack, 1'b0);
    chk("rw_miss_cmd_off", acc_if.acc_cmd, 4'b0000);

    // read FEFF: last byte of ch0 window
    cpu_req(16'hFEFF, 8'h00, 1'b1, 1'b0);
    acc_if.acc_ack   = 2'b01;
    acc_if.acc_rdata = {8'h00, 8'h77};
    tick();
    chk("edge_cmd", acc_if.acc_cmd, 4'b0001);
    chk("edge_addr", acc_if.acc_addr, 16'hFEFF);
    tick();
    chk("edge_ack", cpu_if.xram_ack, 1'b1);
    chk("edge_data", cpu_if.xram_data_in, 8'h77);
    cpu_drop();
    acc_if.acc_ack = 2'b00;
    tick();

    // read 1234: miss
    cpu_req(16'h1234, 8'h00, 1'b1, 1'b0);
    tick();
    chk("miss_ack", cpu_if.xram_ack, 1'b1);
    chk("miss_data", cpu_if.xram_data_in, 8'hFF);
    chk("miss_cmd", acc_if.acc_cmd, 4'b0000);
    cpu_drop();
    tick();
    chk("miss_ack_off", cpu_if.xram_ack, 1'b0);
    chk("miss_data_hold", cpu_if.xram_data_in, 8'hFF);

    // read FE00 with no accelerator response
    cpu_req(16'hFE00, 8'h00, 1'b1, 1'b0);
`ifdef XRAM_ROUTER_TIMEOUT_EN
    for (int k = 1; k <= 15; k++) begin
      tick();
      chk("to_cmd_wait", acc_if.acc_cmd, 4'b0001);
      chk("to_ack_wait", cpu_if.xram_ack, 1'b0);
    end
    tick();
    chk("to_ack", cpu_if.xram_ack, 1'b1);
    chk("to_data", cpu_if.xram_data_in, 8'hFF);
    chk("to_err", err_timeout, 1'b1);
    chk("to_grant", acc_if.acc_grant, 2'b10);
    chk("to_cmd", acc_if.acc_cmd, 4'b0000);
    cpu_drop();
    tick();
    chk("to_ack_off", cpu_if.xram_ack, 1'b0);
    cpu_req(16'hFE00, 8'h21, 1'b0, 1'b1);
    acc_if.acc_ack = 2'b01;
    tick();
    chk("dis_ack", cpu_if.xram_ack, 1'b1);
    chk("dis_cmd", acc_if.acc_cmd, 4'b0000);
    chk("dis_err_sticky", err_timeout, 1'b1);
    cpu_drop();
    acc_if.acc_ack = 2'b00;
    tick();
`else
    for (int k = 1; k <= 20; k++) begin
      tick();
      chk("hang_cmd", acc_if.acc_cmd, 4'b0001);
      chk("hang_ack", cpu_if.xram_ack, 1'b0);
    end
    chk("hang_err", err_timeout, 1'b0);
    chk("hang_grant", acc_if.acc_grant, 2'b11);
    #1 rst = 1'b0;
    #1;
    chk("hang_rst_cmd", acc_if.acc_cmd, 4'b0000);
    cpu_drop();
    tick();
    rst = 1'b1;
    tick();
`endif

    // reset asserted while ch1 is busy
    cpu_req(16'hFF00, 8'h00, 1'b1, 1'b0);
    tick();
    chk("rb_cmd_t1", acc_if.acc_cmd, 4'b0100);
    tick();
    chk("rb_cmd_t2", acc_if.acc_cmd, 4'b0100);
    #1 rst = 1'b0;
    #1;
    chk("rb_cmd_async", acc_if.acc_cmd, 4'b0000);
    chk("rb_ack_async", cpu_if.xram_ack, 1'b0);
    cpu_drop();
    tick();
    chk("rb_ack_in_rst", cpu_if.xram_ack, 1'b0);
    rst = 1'b1;
    tick();
    chk("rb_ack_after", cpu_if.xram_ack, 1'b0);
    chk("rb_grant", acc_if.acc_grant, 2'b11);
    chk("rb_err", err_timeout, 1'b0);
    cpu_req(16'hFF00, 8'h00, 1'b1, 1'b0);
    acc_if.acc_ack   = 2'b10;
    acc_if.acc_rdata = {8'h5C, 8'h00};
    tick();
    chk("rb_rd_cmd", acc_if.acc_cmd, 4'b0100);
    tick();
    chk("rb_rd_ack", cpu_if.xram_ack, 1'b1);
    chk("rb_rd_data", cpu_if.xram_data_in, 8'h5C);
    chk("rb_rd_cmd_off", acc_if.acc_cmd, 4'b0000);
    cpu_drop();
    acc_if.acc_ack = 2'b00;
    tick();
    chk("rb_rd_ack_off", cpu_if.xram_ack, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
